// File: rtl/bp_fe_realigner_rvc_pkg.sv
// Shared types for the front-end realigner: one buffered halfword plus its block-start flag,
// and the RVC length decode on the low two bits of a halfword.
package bp_fe_pkg;

  typedef struct packed {
    logic        blk_start;
    logic [15:0] half;
  } bp_fe_half_entry_s;

  function automatic logic bp_fe_is_compressed(input logic [15:0] half);
    return (half[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/bp_fe_realigner_rvc_if.sv
// Fetch, redirect and instruction handshake bundle between IF2, the realigner and the FE queue.
interface bp_fe_realigner_rvc_if #(
  parameter int vaddr_width_p = 39,
  parameter int fetch_width_p = 64
);

  logic                     fetch_v_i;
  logic                     fetch_ready_and_o;
  logic [vaddr_width_p-1:0] fetch_pc_i;
  logic [fetch_width_p-1:0] fetch_data_i;
  logic                     redirect_v_i;
  logic                     redirect_resume_i;
  logic [15:0]              redirect_partial_i;
  logic [vaddr_width_p-1:0] redirect_vaddr_i;
  logic                     instr_v_o;
  logic [vaddr_width_p-1:0] instr_pc_o;
  logic [31:0]              instr_o;
  logic                     instr_compressed_o;
  logic                     instr_partial_o;
  logic                     instr_yumi_i;

  modport slave (
    input  fetch_v_i, fetch_pc_i, fetch_data_i,
    input  redirect_v_i, redirect_resume_i, redirect_partial_i, redirect_vaddr_i,
    input  instr_yumi_i,
    output fetch_ready_and_o,
    output instr_v_o, instr_pc_o, instr_o, instr_compressed_o, instr_partial_o
  );

  modport master (
    output fetch_v_i, fetch_pc_i, fetch_data_i,
    output redirect_v_i, redirect_resume_i, redirect_partial_i, redirect_vaddr_i,
    output instr_yumi_i,
    input  fetch_ready_and_o,
    input  instr_v_o, instr_pc_o, instr_o, instr_compressed_o, instr_partial_o
  );

endinterface

// File: rtl/bp_fe_realigner_rvc_hbuf.sv
// Circular halfword buffer: writes the useful tail of a fetch block in one cycle and
// exposes the two halves at the head for instruction extraction.
module bp_fe_realigner_hbuf
  import bp_fe_pkg::*;
#(
  parameter int fetch_width_p = 64,
  parameter int buf_halves_p  = 8
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  i_enq_v,
  input  logic [$clog2(fetch_width_p/16)-1:0]   i_enq_idx,
  input  logic [fetch_width_p-1:0]              i_enq_data,
  input  logic                                  i_deq_v,
  input  logic                                  i_deq_two,
  input  logic                                  i_flush,
  input  logic                                  i_load,
  input  logic [15:0]                           i_load_half,
  output logic [$clog2(buf_halves_p):0]         o_count,
  output logic [15:0]                           o_head0_half,
  output bp_fe_half_entry_s                     o_head1
);

  localparam int H  = fetch_width_p / 16;
  localparam int PW = $clog2(buf_halves_p);
  localparam int CW = PW + 1;

  bp_fe_half_entry_s r_mem [buf_halves_p];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_n_enq;
  logic [CW-1:0]     w_n_deq;

  assign w_n_enq = i_enq_v ? (CW'(H) - CW'(i_enq_idx)) : '0;
  assign w_n_deq = i_deq_v ? (i_deq_two ? CW'(2) : CW'(1)) : '0;

  // Halves below the block's start index are skipped; the first kept half is tagged as a block start.
  always_ff @(posedge clk_i) begin
    if (i_load) begin
      r_mem[0] <= '{blk_start: 1'b1, half: i_load_half};
    end else if (i_enq_v) begin
      for (int k = 0; k < H; k++) begin
        if (k >= int'(i_enq_idx)) begin
          r_mem[r_tail + PW'(k - int'(i_enq_idx))] <=
            '{blk_start: (k == int'(i_enq_idx)), half: i_enq_data[16*k +: 16]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= i_load ? PW'(1) : '0;
      r_count <= i_load ? CW'(1) : '0;
    end else begin
      r_head  <= r_head + PW'(w_n_deq);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= r_count + w_n_enq - w_n_deq;
    end
  end

  assign o_count      = r_count;
  assign o_head0_half = r_mem[r_head].half;
  assign o_head1      = r_mem[r_head + PW'(1)];

endmodule

// File: rtl/bp_fe_realigner_rvc.sv
// Realigner between IF2 and the FE queue: decodes RVC/32-bit length at the buffer head,
// tracks the head PC and handles poison and resume redirects.
module bp_fe_realigner_rvc
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int fetch_width_p = 64,
  parameter int buf_halves_p  = 8,
  parameter int compressed_p  = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_fe_realigner_rvc_if.slave    io
);

  localparam int H  = fetch_width_p / 16;
  localparam int IW = $clog2(H);
  localparam int CW = $clog2(buf_halves_p) + 1;

  logic [CW-1:0]            w_count;
  logic [15:0]              w_h0;
  bp_fe_half_entry_s        w_h1;
  logic [IW-1:0]            w_idx;
  logic                     w_comp;
  logic                     w_avail;
  logic                     w_instr_v;
  logic                     w_ready;
  logic                     w_enq;
  logic                     w_deq;
  logic [vaddr_width_p-1:0] r_head_pc;

  assign w_idx     = io.fetch_pc_i[$clog2(fetch_width_p/8)-1:1];
  assign w_comp    = (compressed_p != 0) && bp_fe_is_compressed(w_h0);
  assign w_avail   = w_comp ? (w_count >= CW'(1)) : (w_count >= CW'(2));
  assign w_instr_v = w_avail & ~io.redirect_v_i;
  assign w_ready   = reset_n_i & (w_count <= CW'(buf_halves_p - H));
  assign w_enq     = io.fetch_v_i & w_ready & ~io.redirect_v_i;
  assign w_deq     = io.instr_yumi_i & w_instr_v;

  bp_fe_realigner_hbuf #(
    .fetch_width_p (fetch_width_p),
    .buf_halves_p  (buf_halves_p)
  ) u_hbuf (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .i_enq_v      (w_enq),
    .i_enq_idx    (w_idx),
    .i_enq_data   (io.fetch_data_i),
    .i_deq_v      (w_deq),
    .i_deq_two    (~w_comp),
    .i_flush      (io.redirect_v_i),
    .i_load       (io.redirect_v_i & io.redirect_resume_i),
    .i_load_half  (io.redirect_partial_i),
    .o_count      (w_count),
    .o_head0_half (w_h0),
    .o_head1      (w_h1)
  );

  // A resumed half sits one halfword before the redirect PC; an empty buffer adopts the block PC.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head_pc <= '0;
    end else if (io.redirect_v_i) begin
      r_head_pc <= io.redirect_resume_i ? (io.redirect_vaddr_i - vaddr_width_p'(2))
                                        : io.redirect_vaddr_i;
    end else if (w_enq && (w_count == '0)) begin
      r_head_pc <= io.fetch_pc_i;
    end else if (w_deq) begin
      r_head_pc <= r_head_pc + vaddr_width_p'(w_comp ? 2 : 4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && w_enq && (w_count != '0)) begin
      assert (io.fetch_pc_i == r_head_pc + vaddr_width_p'({w_count, 1'b0}));
    end
  end

  assign io.fetch_ready_and_o  = w_ready;
  assign io.instr_v_o          = w_instr_v;
  assign io.instr_pc_o         = w_instr_v ? r_head_pc : '0;
  assign io.instr_o            = !w_instr_v ? 32'b0 : (w_comp ? {16'b0, w_h0} : {w_h1.half, w_h0});
  assign io.instr_compressed_o = w_instr_v & w_comp;
  assign io.instr_partial_o    = w_instr_v & ~w_comp & w_h1.blk_start;

endmodule

// File: tb/tb_bp_fe_realigner_rvc.sv
// Scoreboard bench for the RVC realigner: expected instructions are queued as blocks are sent
// and compared by a monitor whenever the DUT hands one over.
module tb_bp_fe_realigner_rvc;

  typedef struct {
    logic [38:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic        part;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  exp_t sb_head;

  bp_fe_realigner_rvc_if #(.vaddr_width_p(39), .fetch_width_p(64)) bus ();

  bp_fe_realigner_rvc #(
    .vaddr_width_p (39),
    .fetch_width_p (64),
    .buf_halves_p  (8),
    .compressed_p  (1)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .io        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Every handed-over instruction (valid & yumi) is matched against the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (reset_n && bus.instr_v_o && bus.instr_yumi_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_instr: got pc %h instr %h, required none", bus.instr_pc_o, bus.instr_o);
      end else begin
        sb_head = sb.pop_front();
        if (bus.instr_pc_o !== sb_head.pc) begin
          errors++;
          $display("[TB] FAIL instr_pc: got %h, required %h", bus.instr_pc_o, sb_head.pc);
        end
        checks++;
        if (bus.instr_o !== sb_head.instr) begin
          errors++;
          $display("[TB] FAIL instr_data: got %h, required %h (pc %h)", bus.instr_o, sb_head.instr, sb_head.pc);
        end
        checks++;
        if (bus.instr_compressed_o !== sb_head.comp) begin
          errors++;
          $display("[TB] FAIL instr_compressed: got %b, required %b (pc %h)", bus.instr_compressed_o, sb_head.comp, sb_head.pc);
        end
        checks++;
        if (bus.instr_partial_o !== sb_head.part) begin
          errors++;
          $display("[TB] FAIL instr_partial: got %b, required %b (pc %h)", bus.instr_partial_o, sb_head.part, sb_head.pc);
        end
      end
    end
  end

  task automatic push_exp(input logic [38:0] pc, input logic [31:0] instr, input logic comp, input logic part);
    exp_t e;
    e.pc = pc; e.instr = instr; e.comp = comp; e.part = part;
    sb.push_back(e);
  endtask

  task automatic push_rvc(input logic [38:0] pc);
    push_exp(pc, 32'h0000_4505, 1'b1, 1'b0);
  endtask

  task automatic send_block(input logic [38:0] pc, input logic [63:0] data);
    int n = 0;
    @(negedge clk);
    bus.fetch_v_i    = 1'b1;
    bus.fetch_pc_i   = pc;
    bus.fetch_data_i = data;
    #1;
    while (!bus.fetch_ready_and_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_block_timeout: ready stayed 0, required 1 (pc %h)", pc);
    end
    @(negedge clk);
    bus.fetch_v_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      bus.instr_yumi_i = bus.instr_v_o;
      #2;
      n++;
    end
    @(negedge clk);
    bus.instr_yumi_i = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected instrs left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_v: got %b, required 0", bus.instr_v_o); end
    checks++;
    if (bus.fetch_ready_and_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b, required 0", bus.fetch_ready_and_o); end
    checks++;
    if (bus.instr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h, required 0", bus.instr_o); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.fetch_ready_and_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b, required 1", bus.fetch_ready_and_o); end
  endtask

  task automatic test_rvc_stream();
    for (int i = 0; i < 4; i++) push_rvc(39'h1000 + 39'(2*i));
    send_block(39'h1000, {4{16'h4505}});
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b1) begin errors++; $display("[TB] FAIL latency_instr_v: got %b, required 1", bus.instr_v_o); end
    drain(20);
  endtask

  task automatic test_split_instr();
    for (int i = 0; i < 3; i++) push_rvc(39'h1000 + 39'(2*i));
    push_exp(39'h1006, 32'h00a0_0513, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push_rvc(39'h100a + 39'(2*i));
    send_block(39'h1000, {16'h0513, 16'h4505, 16'h4505, 16'h4505});
    send_block(39'h1008, {16'h4505, 16'h4505, 16'h4505, 16'h00a0});
    drain(30);
  endtask

  task automatic test_mid_block_pc();
    for (int i = 0; i < 3; i++) push_rvc(39'h1002 + 39'(2*i));
    send_block(39'h1002, {16'h4505, 16'h4505, 16'h4505, 16'hffff});
    drain(20);
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_block_leftover: instr_v got %b, required 0", bus.instr_v_o); end
  endtask

  task automatic test_back_to_back();
    push_exp(39'h3000, 32'h00a0_0513, 1'b0, 1'b0);
    push_exp(39'h3004, 32'h00b0_0593, 1'b0, 1'b0);
    push_exp(39'h3008, 32'h00c0_0613, 1'b0, 1'b0);
    push_exp(39'h300c, 32'h00d0_0693, 1'b0, 1'b0);
    send_block(39'h3000, {32'h00b0_0593, 32'h00a0_0513});
    send_block(39'h3008, {32'h00d0_0693, 32'h00c0_0613});
    #1;
    checks++;
    if (bus.fetch_ready_and_o !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b, required 0", bus.fetch_ready_and_o); end
    bus.instr_yumi_i = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.fetch_ready_and_o !== 1'b0) begin errors++; $display("[TB] FAIL six_ready: got %b, required 0", bus.fetch_ready_and_o); end
    @(negedge clk);
    bus.instr_yumi_i = 1'b0;
    #1;
    checks++;
    if (bus.fetch_ready_and_o !== 1'b1) begin errors++; $display("[TB] FAIL four_ready: got %b, required 1", bus.fetch_ready_and_o); end
    drain(20);
  endtask

  task automatic test_resume();
    @(negedge clk);
    bus.redirect_v_i       = 1'b1;
    bus.redirect_resume_i  = 1'b1;
    bus.redirect_partial_i = 16'h0513;
    bus.redirect_vaddr_i   = 39'h2002;
    @(negedge clk);
    bus.redirect_v_i      = 1'b0;
    bus.redirect_resume_i = 1'b0;
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL resume_half_only: instr_v got %b, required 0", bus.instr_v_o); end
    push_exp(39'h2000, 32'h00a0_0513, 1'b0, 1'b1);
    push_rvc(39'h2004);
    push_rvc(39'h2006);
    send_block(39'h2002, {16'h4505, 16'h4505, 16'h00a0, 16'hffff});
    drain(20);
    push_rvc(39'h7000);
    @(negedge clk);
    bus.redirect_v_i       = 1'b1;
    bus.redirect_resume_i  = 1'b1;
    bus.redirect_partial_i = 16'h4505;
    bus.redirect_vaddr_i   = 39'h7002;
    @(negedge clk);
    bus.redirect_v_i      = 1'b0;
    bus.redirect_resume_i = 1'b0;
    drain(10);
  endtask

  task automatic test_poison();
    send_block(39'h4000, {32'h00b0_0593, 32'h00a0_0513});
    send_block(39'h4008, {32'h00d0_0693, 32'h00c0_0613});
    @(negedge clk);
    bus.redirect_v_i      = 1'b1;
    bus.redirect_resume_i = 1'b0;
    bus.redirect_vaddr_i  = 39'h0;
    bus.instr_yumi_i      = 1'b1;
    bus.fetch_v_i         = 1'b1;
    bus.fetch_pc_i        = 39'h4010;
    bus.fetch_data_i      = {4{16'h4505}};
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL poison_mask: instr_v got %b, required 0", bus.instr_v_o); end
    @(negedge clk);
    bus.redirect_v_i = 1'b0;
    bus.instr_yumi_i = 1'b0;
    bus.fetch_v_i    = 1'b0;
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL poison_empty: instr_v got %b, required 0", bus.instr_v_o); end
    checks++;
    if (bus.fetch_ready_and_o !== 1'b1) begin errors++; $display("[TB] FAIL poison_ready: got %b, required 1", bus.fetch_ready_and_o); end
    for (int i = 0; i < 4; i++) push_rvc(39'h5000 + 39'(2*i));
    send_block(39'h5000, {4{16'h4505}});
    drain(20);
  endtask

  task automatic test_async_reset();
    send_block(39'h6000, {4{16'h4505}});
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_instr_v: got %b, required 1", bus.instr_v_o); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_instr_v: got %b, required 0", bus.instr_v_o); end
    checks++;
    if (bus.instr_o !== 32'h0 || bus.instr_pc_o !== 39'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_data: got instr %h pc %h, required 0 0", bus.instr_o, bus.instr_pc_o);
    end
    checks++;
    if (bus.fetch_ready_and_o !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ready: got %b, required 0", bus.fetch_ready_and_o); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.instr_v_o !== 1'b0) begin errors++; $display("[TB] FAIL post_async_empty: instr_v got %b, required 0", bus.instr_v_o); end
    for (int i = 0; i < 4; i++) push_rvc(39'h8000 + 39'(2*i));
    send_block(39'h8000, {4{16'h4505}});
    drain(20);
  endtask

  initial begin
    reset_n                = 1'b0;
    bus.fetch_v_i          = 1'b0;
    bus.fetch_pc_i         = '0;
    bus.fetch_data_i       = '0;
    bus.redirect_v_i       = 1'b0;
    bus.redirect_resume_i  = 1'b0;
    bus.redirect_partial_i = '0;
    bus.redirect_vaddr_i   = '0;
    bus.instr_yumi_i       = 1'b0;
    test_reset();
    test_rvc_stream();
    test_split_instr();
    test_mid_block_pc();
    test_back_to_back();
    test_resume();
    test_poison();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
